// File: rtl/data_ram.sv
// data_ram: word-organised data memory with a fixed-latency request/response handshake.
//
// A request is accepted in IDLE when either enable is high. It waits WAIT_STATES cycles,
// then completes in a single RESP cycle that pulses mem_ready. Stores commit and loads
// update mem_read_data on the clock edge that enters RESP. Misaligned accesses, illegal
// funct3 codes, out-of-range addresses and requests with both enables high all complete
// with mem_fault set. Faulting stores leave memory untouched. Faulting loads return zero.
//
// Ports:
//   clk              clock; all state updates on the rising edge
//   rst              asynchronous active-high reset (memory contents are not reset)
//   mem_addr         byte address
//   mem_write_data   store data, right-aligned
//   mem_write_enable store request
//   mem_read_enable  load request
//   mem_funct3       size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_read_data    load result, held until the next load completes
//   mem_ready        one-cycle completion pulse
//   mem_busy         high while a request is in flight
//   mem_fault        error flag, valid only with mem_ready
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_enable,
    input  logic        mem_read_enable,
    input  logic [2:0]  mem_funct3,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_fault
);

    localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic        we_q, re_q, fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    // The operation being processed: live inputs while idle, latched copy afterwards.
    // This lets the zero-wait case commit on the acceptance edge itself.
    logic             is_idle, accept, enter_resp;
    logic [31:0]      cur_addr, cur_wdata, wshift, rword, load_val;
    logic [2:0]       cur_f3;
    logic             cur_we, cur_re, cur_fault;
    logic [AddrW-1:0] cur_idx;
    logic [3:0]       be;
    logic [15:0]      rhalf;
    logic [7:0]       rbyte;

    always_comb begin
        is_idle   = (state_q == StIdle);
        cur_addr  = is_idle ? mem_addr : addr_q;
        cur_wdata = is_idle ? mem_write_data : wdata_q;
        cur_f3    = is_idle ? mem_funct3 : f3_q;
        cur_we    = is_idle ? mem_write_enable : we_q;
        cur_re    = is_idle ? mem_read_enable : re_q;
        cur_idx   = cur_addr[AddrW+1:2];
        accept    = is_idle && (mem_read_enable || mem_write_enable);

        cur_fault = (cur_we && cur_re)
                 || (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111)
                 || (cur_we && cur_f3[2])
                 || ((cur_f3[1:0] == 2'b01) && cur_addr[0])
                 || ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00))
                 || (cur_addr[31:AddrW+2] != '0);

        wshift = cur_wdata << {cur_addr[1:0], 3'b000};
        case (cur_f3[1:0])
            2'b00:   be = 4'b0001 << cur_addr[1:0];
            2'b01:   be = 4'b0011 << {cur_addr[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        rword = mem[cur_idx];
        rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];
        case (cur_addr[1:0])
            2'b00:   rbyte = rword[7:0];
            2'b01:   rbyte = rword[15:8];
            2'b10:   rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        case (cur_f3)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_val = {24'b0, rbyte};
            3'b101:  load_val = {16'b0, rhalf};
            default: load_val = rword;
        endcase
    end

    // Next-state and wait counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_write_data;
                f3_q    <= mem_funct3;
                we_q    <= mem_write_enable;
                re_q    <= mem_read_enable;
            end
            if (enter_resp) begin
                fault_q <= cur_fault;
                // Both-enables requests are faults that must not disturb the held load data.
                if (cur_re && !cur_we) begin
                    rdata_q <= cur_fault ? 32'd0 : load_val;
                end
            end
        end
    end

    // Memory array has no reset; rst also blocks a commit that would coincide with it.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_we && !cur_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[cur_idx][8*i +: 8] <= wshift[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        mem_read_data = rdata_q;
        mem_ready     = (state_q == StResp);
        mem_busy      = (state_q != StIdle);
        mem_fault     = (state_q == StResp) && fault_q;
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram. Three instances: 0 -> WAIT_STATES=1, 1 -> WAIT_STATES=3,
// 2 -> WAIT_STATES=0, all with DEPTH_WORDS=1024.
module tb_data_ram;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;

    logic        clk;
    logic        a_rst  [3];
    logic [31:0] a_addr [3];
    logic [31:0] a_wd   [3];
    logic        a_we   [3];
    logic        a_re   [3];
    logic [2:0]  a_f3   [3];
    logic [31:0] a_rd   [3];
    logic        a_rdy  [3];
    logic        a_busy [3];
    logic        a_flt  [3];

    int checks = 0;
    int errors = 0;

    data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(a_rst[0]), .mem_addr(a_addr[0]), .mem_write_data(a_wd[0]),
        .mem_write_enable(a_we[0]), .mem_read_enable(a_re[0]), .mem_funct3(a_f3[0]),
        .mem_read_data(a_rd[0]), .mem_ready(a_rdy[0]), .mem_busy(a_busy[0]),
        .mem_fault(a_flt[0])
    );
    data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(a_rst[1]), .mem_addr(a_addr[1]), .mem_write_data(a_wd[1]),
        .mem_write_enable(a_we[1]), .mem_read_enable(a_re[1]), .mem_funct3(a_f3[1]),
        .mem_read_data(a_rd[1]), .mem_ready(a_rdy[1]), .mem_busy(a_busy[1]),
        .mem_fault(a_flt[1])
    );
    data_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(a_rst[2]), .mem_addr(a_addr[2]), .mem_write_data(a_wd[2]),
        .mem_write_enable(a_we[2]), .mem_read_enable(a_re[2]), .mem_funct3(a_f3[2]),
        .mem_read_data(a_rd[2]), .mem_ready(a_rdy[2]), .mem_busy(a_busy[2]),
        .mem_fault(a_flt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, report the edges from acceptance to ready (acceptance edge is 1;
    // 0 means ready never came), then step one more edge so the DUT is back in IDLE.
    task automatic issue(input int k, input logic we, input logic re, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic flt);
        lat = 0;
        rd  = 32'd0;
        flt = 1'b0;
        @(negedge clk);
        a_we[k] = we; a_re[k] = re; a_f3[k] = f3; a_addr[k] = addr; a_wd[k] = wd;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            a_we[k] = 1'b0; a_re[k] = 1'b0;
            if (a_rdy[k]) begin
                lat = i; rd = a_rd[k]; flt = a_flt[k];
                break;
            end
        end
        if (lat != 0) @(posedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            a_rst[k] = 1'b1; a_we[k] = 1'b0; a_re[k] = 1'b0;
            a_f3[k] = 3'd0; a_addr[k] = 32'd0; a_wd[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (a_rdy[k] !== 1'b0) begin
                errors++; $display("FAIL reset_ready[%0d] got %b exp 0", k, a_rdy[k]);
            end
            if (a_busy[k] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d] got %b exp 0", k, a_busy[k]);
            end
            if (a_flt[k] !== 1'b0) begin
                errors++; $display("FAIL reset_fault[%0d] got %b exp 0", k, a_flt[k]);
            end
            if (a_rd[k] !== 32'd0) begin
                errors++; $display("FAIL reset_rdata[%0d] got %h exp 0", k, a_rd[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) a_rst[k] = 1'b0;
    endtask

    // Runs a vector list on instance k, checking latency, fault and read data.
    task automatic run_vecs(input string name, input int k, input int exp_lat,
                            input vec_t v[$]);
        int          lat;
        logic [31:0] rd;
        logic        flt;
        foreach (v[i]) begin
            issue(k, v[i].we, !v[i].we, v[i].f3, v[i].addr, v[i].wd, lat, rd, flt);
            checks += 3;
            if (lat != exp_lat) begin
                errors++; $display("FAIL %s[%0d]_latency got %0d exp %0d", name, i, lat, exp_lat);
            end
            if (flt !== v[i].exp_flt) begin
                errors++; $display("FAIL %s[%0d]_fault got %b exp %b", name, i, flt, v[i].exp_flt);
            end
            if (rd !== v[i].exp_rd) begin
                errors++; $display("FAIL %s[%0d]_rdata got %h exp %h", name, i, rd, v[i].exp_rd);
            end
        end
    endtask

    task automatic test_word();
        vec_t v[$];
        v.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0});
        v.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
        run_vecs("word", 0, 2, v);
    endtask

    task automatic test_byte_half();
        vec_t v[$];
        v.push_back('{1'b1, 3'b000, 32'h11, 32'h00000080, 32'hDEADBEEF, 1'b0}); // SB
        v.push_back('{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0}); // LB
        v.push_back('{1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0}); // LBU
        v.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0}); // LW
        v.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0}); // LH
        v.push_back('{1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0}); // LHU
        v.push_back('{1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0000DEAD, 1'b0}); // SH
        v.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 1'b0});
        v.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000012, 1'b0});
        v.push_back('{1'b1, 3'b000, 32'h10, 32'hAAAAAA01, 32'h00000012, 1'b0}); // SB
        v.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h12348001, 1'b0});
        run_vecs("bytehalf", 0, 2, v);
    endtask

    task automatic test_fault();
        vec_t v[$];
        v.push_back('{1'b0, 3'b001, 32'h13,   32'h0,        32'h0,        1'b1}); // LH misaligned
        v.push_back('{1'b1, 3'b010, 32'h0,    32'hA5A5A5A5, 32'h0,        1'b0});
        v.push_back('{1'b1, 3'b010, 32'h1000, 32'h11111111, 32'h0,        1'b1}); // out of range
        v.push_back('{1'b0, 3'b010, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b0, 3'b010, 32'h2,    32'h0,        32'h0,        1'b1}); // LW misaligned
        v.push_back('{1'b0, 3'b011, 32'h0,    32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b1, 3'b100, 32'h1,    32'h0,        32'hA5A5A5A5, 1'b1}); // store f3 100
        v.push_back('{1'b1, 3'b001, 32'h1,    32'h0,        32'hA5A5A5A5, 1'b1}); // SH misaligned
        v.push_back('{1'b0, 3'b110, 32'h0,    32'h0,        32'h0,        1'b1});
        v.push_back('{1'b0, 3'b010, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0});
        v.push_back('{1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1});
        v.push_back('{1'b1, 3'b010, 32'hFFC,  32'h80000000, 32'h0,        1'b0}); // last word
        v.push_back('{1'b0, 3'b000, 32'hFFF,  32'h0,        32'hFFFFFF80, 1'b0});
        run_vecs("fault", 0, 2, v);
    endtask

    task automatic test_dual();
        int          lat;
        logic [31:0] rd;
        logic        flt;
        issue(0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0, lat, rd, flt);
        checks += 3;
        if (lat != 2) begin errors++; $display("FAIL dual_latency got %0d exp 2", lat); end
        if (flt !== 1'b1) begin errors++; $display("FAIL dual_fault got %b exp 1", flt); end
        if (rd !== 32'hFFFFFF80) begin
            errors++; $display("FAIL dual_rdata got %h exp ffffff80", rd);
        end
        issue(0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, lat, rd, flt);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL dual_mem got %h exp a5a5a5a5", rd);
        end
    endtask

    task automatic test_busy_ignore();
        int          nrdy = 0;
        int          lat;
        logic [31:0] rd;
        logic        flt;
        @(negedge clk);
        a_we[0] = 1'b0; a_re[0] = 1'b1; a_f3[0] = 3'b010; a_addr[0] = 32'h10; a_wd[0] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            // Swap to a store while the load is in flight; it must be ignored.
            if (i == 0) begin a_we[0] = 1'b1; a_re[0] = 1'b0; end
            if (a_rdy[0]) begin
                nrdy++;
                a_we[0] = 1'b0; a_re[0] = 1'b0;
                checks++;
                if (a_rd[0] !== 32'h12348001) begin
                    errors++; $display("FAIL busy_rdata got %h exp 12348001", a_rd[0]);
                end
            end
        end
        checks++;
        if (nrdy != 1) begin errors++; $display("FAIL busy_ready_count got %0d exp 1", nrdy); end
        issue(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, lat, rd, flt);
        checks++;
        if (rd !== 32'h12348001) begin
            errors++; $display("FAIL busy_mem got %h exp 12348001", rd);
        end
    endtask

    task automatic test_reset_abort();
        int          lat;
        int          nrdy = 0;
        logic [31:0] rd;
        logic        flt;
        issue(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'hCAFEF00D, lat, rd, flt);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL abort_prep_latency got %0d exp 4", lat); end
        @(negedge clk);
        a_we[1] = 1'b1; a_f3[1] = 3'b010; a_addr[1] = 32'h20; a_wd[1] = 32'h12345678;
        @(posedge clk); #1;
        a_we[1] = 1'b0;
        @(posedge clk); #1;
        a_rst[1] = 1'b1;
        #1;
        checks += 2;
        if (a_busy[1] !== 1'b0) begin
            errors++; $display("FAIL abort_busy got %b exp 0", a_busy[1]);
        end
        if (a_rdy[1] !== 1'b0) begin
            errors++; $display("FAIL abort_ready got %b exp 0", a_rdy[1]);
        end
        @(posedge clk);
        @(negedge clk);
        a_rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_rdy[1]) nrdy++;
        end
        checks++;
        if (nrdy != 0) begin errors++; $display("FAIL abort_no_ready got %0d exp 0", nrdy); end
        issue(1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, lat, rd, flt);
        checks += 2;
        if (lat != 4) begin errors++; $display("FAIL abort_load_latency got %0d exp 4", lat); end
        if (rd !== 32'hCAFEF00D) begin
            errors++; $display("FAIL abort_mem got %h exp cafef00d", rd);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] rd;
        logic        flt;
        logic        exp;
        issue(2, 1'b1, 1'b0, 3'b010, 32'h4, 32'h0BADF00D, lat, rd, flt);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL b2b_store_latency got %0d exp 1", lat); end
        @(negedge clk);
        a_re[2] = 1'b1; a_f3[2] = 3'b010; a_addr[2] = 32'h4;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp = (i % 2 == 0);
            checks += 2;
            if (a_rdy[2] !== exp) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", i, a_rdy[2], exp);
            end
            if (a_busy[2] !== exp) begin
                errors++; $display("FAIL b2b_busy[%0d] got %b exp %b", i, a_busy[2], exp);
            end
            if (exp) begin
                checks++;
                if (a_rd[2] !== 32'h0BADF00D) begin
                    errors++; $display("FAIL b2b_rdata[%0d] got %h exp 0badf00d", i, a_rd[2]);
                end
            end
        end
        a_re[2] = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_fault();
        test_dual();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
